// File: rtl/noc_merge_arbiter.sv
// noc_merge_arbiter: clocked 2:1 round-robin merge of two 9-bit NoC packet
// streams onto one registered output link, with a source tag per packet.
// Each input owns a one-entry holding register; the grant is taken only from
// registered state and out_ready, so the input valids never reach the grant.
// Optional per-input saturating grant counters are built when the macro
// NOC_MERGE_ARBITER_STATS_EN is defined.

module noc_merge_arbiter #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready
`ifdef NOC_MERGE_ARBITER_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    logic [1:0]       hold_full_r;
    logic [WIDTH-1:0] hold_data0_r;
    logic [WIDTH-1:0] hold_data1_r;
    logic             out_valid_r;
    logic             out_src_r;
    logic [WIDTH-1:0] out_data_r;
    logic             rr_last_r;

    logic             slot_free_s;
    logic             grant_valid_s;
    logic             grant_sel_s;
    logic [WIDTH-1:0] grant_data_s;
    logic             cap0_s;
    logic             cap1_s;

    // Pick the next holding register to forward; the tie goes to the input not granted last.
    always_comb begin
        slot_free_s   = !out_valid_r || out_ready;
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
        if (slot_free_s) begin
            case (hold_full_r)
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_sel_s   = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_sel_s   = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_sel_s   = !rr_last_r;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_sel_s   = 1'b0;
                end
            endcase
        end else begin
            grant_valid_s = 1'b0;
            grant_sel_s   = 1'b0;
        end
        if (grant_sel_s) begin
            grant_data_s = hold_data1_r;
        end else begin
            grant_data_s = hold_data0_r;
        end
    end

    // Accept a new packet when the slot is empty or is being drained this same edge.
    always_comb begin
        in0_ready = !RESET && (!hold_full_r[0] || (grant_valid_s && !grant_sel_s));
        in1_ready = !RESET && (!hold_full_r[1] || (grant_valid_s &&  grant_sel_s));
        cap0_s    = in0_valid && in0_ready;
        cap1_s    = in1_valid && in1_ready;
    end

    // Holding registers: a capture wins over a drain so a streaming input stays full.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_full_r  <= 2'b00;
            hold_data0_r <= {WIDTH{1'b0}};
            hold_data1_r <= {WIDTH{1'b0}};
        end else begin
            if (cap0_s) begin
                hold_data0_r   <= in0_data;
                hold_full_r[0] <= 1'b1;
            end else if (grant_valid_s && !grant_sel_s) begin
                hold_full_r[0] <= 1'b0;
            end
            if (cap1_s) begin
                hold_data1_r   <= in1_data;
                hold_full_r[1] <= 1'b1;
            end else if (grant_valid_s && grant_sel_s) begin
                hold_full_r[1] <= 1'b0;
            end
        end
    end

    // Output register and round-robin pointer; rr_last starts at 1 so input 0 wins the first tie.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_src_r   <= 1'b0;
            rr_last_r   <= 1'b1;
        end else if (grant_valid_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_src_r   <= grant_sel_s;
            rr_last_r   <= grant_sel_s;
        end else if (slot_free_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

`ifdef NOC_MERGE_ARBITER_STATS_EN
    logic [CNT_W-1:0] grant0_cnt_r;
    logic [CNT_W-1:0] grant1_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    // Saturating grant counters; a clear beats an increment on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET || stats_clr) begin
            grant0_cnt_r <= {CNT_W{1'b0}};
            grant1_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (grant_valid_s && !grant_sel_s) begin
                grant0_cnt_r <= sat_inc(grant0_cnt_r);
            end
            if (grant_valid_s && grant_sel_s) begin
                grant1_cnt_r <= sat_inc(grant1_cnt_r);
            end
        end
    end

    assign grant0_cnt = grant0_cnt_r;
    assign grant1_cnt = grant1_cnt_r;
`else
    // CNT_W only sizes the grant counters, which are not built here.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Directed self-checking bench for noc_merge_arbiter: reset, single-input
// streaming, contention fairness, backpressure, reset mid-traffic and, when
// NOC_MERGE_ARBITER_STATS_EN is defined, the saturating grant counters.

module tb_noc_merge_arbiter;

    localparam int WIDTH = 9;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [WIDTH-1:0] in0_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;
`ifdef NOC_MERGE_ARBITER_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] grant0_cnt;
    logic [CNT_W-1:0] grant1_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    noc_merge_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NOC_MERGE_ARBITER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant0_cnt(grant0_cnt),
        .grant1_cnt(grant1_cnt)
`endif
    );

    // 10-unit clock.
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int n0;
        int n1;
        bit exp_r0;
        bit exp_r1;
        int p;

        RESET     = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 9'h1A5;
        in1_valid = 1'b0;
        in1_data  = 9'h000;
        out_ready = 1'b1;
`ifdef NOC_MERGE_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif

        // ---------------- reset ----------------
        tick(); tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_src",   out_src,   0);
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        RESET = 1'b0;
        #1;
        chk("post_rst_in0_ready", in0_ready, 1);
        tick();                           // capture 1A5
        in0_valid = 1'b0;
        chk("lat_no_out_yet", out_valid, 0);
        tick();                           // grant 0
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data",  out_data,  9'h1A5);
        chk("lat_out_src",   out_src,   0);
        tick();
        chk("lat_drained", out_valid, 0);

        // ---------------- single-input streaming on in1 ----------------
        for (int i = 1; i <= 8; i++) begin
            in1_data  = 9'(i);
            in1_valid = 1'b1;
            #1;
            chk("stream_in1_ready", in1_ready, 1);
            tick();
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_data",  out_data,  32'(i - 1));
                chk("stream_src",   out_src,   1);
            end
        end
        in1_valid = 1'b0;
        tick();
        chk("stream_last_data", out_data, 9'h008);
        chk("stream_last_src",  out_src,  1);
        tick();
        chk("stream_idle", out_valid, 0);

        // ---------------- contention fairness ----------------
        n0 = 0;
        n1 = 0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            in0_data = 9'(n0);
            in1_data = 9'h100 + 9'(n1);
            exp_r0 = (k == 1) || (k % 2 == 0);
            exp_r1 = (k == 1) || (k % 2 == 1);
            #1;
            chk("cont_in0_ready", in0_ready, exp_r0);
            chk("cont_in1_ready", in1_ready, exp_r1);
            tick();
            if (exp_r0) n0++;
            if (exp_r1) n1++;
            if (k >= 2) begin
                p = k - 2;
                chk("cont_valid", out_valid, 1);
                chk("cont_src",   out_src,   p % 2);
                chk("cont_data",  out_data,  (p % 2 == 1) ? 32'h100 + p / 2 : 32'(p / 2));
            end
        end

        // ---------------- backpressure with both holds full ----------------
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_in0_ready", in0_ready, 0);
            chk("bp_in1_ready", in1_ready, 0);
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_data",  out_data,  9'h109);
            chk("bp_src",   out_src,   1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_drain0_data", out_data, 9'h00A);
        chk("bp_drain0_src",  out_src,  0);
        tick();
        chk("bp_drain1_data", out_data, 9'h10A);
        chk("bp_drain1_src",  out_src,  1);
        tick();
        chk("bp_drain_idle", out_valid, 0);

        // ---------------- reset mid-traffic ----------------
        out_ready = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 9'h055;
        in1_valid = 1'b1;
        in1_data  = 9'h1AA;
        tick();                           // capture both
        tick();                           // grant 0, in0 refills
        chk("mid_setup_valid", out_valid, 1);
        chk("mid_setup_data",  out_data,  9'h055);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        RESET = 1'b1;
        #1;
        chk("mid_rst_in0_ready", in0_ready, 0);
        chk("mid_rst_in1_ready", in1_ready, 0);
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data",  out_data,  0);
        RESET     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_no_stale_a", out_valid, 0);
        tick();
        chk("mid_no_stale_b", out_valid, 0);
        in0_valid = 1'b1;
        in0_data  = 9'h0C3;
        in1_valid = 1'b1;
        in1_data  = 9'h13C;
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        chk("mid_post_idle", out_valid, 0);
        tick();
        chk("mid_post0_data", out_data, 9'h0C3);
        chk("mid_post0_src",  out_src,  0);
        tick();
        chk("mid_post1_data", out_data, 9'h13C);
        chk("mid_post1_src",  out_src,  1);
        tick();
        chk("mid_post_end", out_valid, 0);

`ifdef NOC_MERGE_ARBITER_STATS_EN
        // ---------------- grant counters ----------------
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("cnt_clr0", grant0_cnt, 0);
        chk("cnt_clr1", grant1_cnt, 0);
        for (int k = 1; k <= 22; k++) begin
            in0_valid = 1'b1;
            in0_data  = 9'(k);
            tick();
        end
        chk("cnt_sat0", grant0_cnt, 15);
        chk("cnt_none1", grant1_cnt, 0);
        in0_valid = 1'b0;
        stats_clr = 1'b1;
        tick();                           // grant of packet 22 with clear
        stats_clr = 1'b0;
        chk("cnt_clr_grant_data", out_data, 9'h016);
        chk("cnt_clr_priority",   grant0_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
